// File: rtl/aib_rx_unpacker.sv
// AIB receive-side flit reassembler: strips per-beat control bits, pairs 36-bit beats
// into 72-bit flits and queues them toward the core behind a valid/ready handshake.
module aib_rx_unpacker #(
    parameter int DEPTH       = 8,
    parameter int FULL_MARGIN = 4
) (
    input  logic        i_aib_rx_clk,
    input  logic        i_rst,
    input  logic [19:0] i_rx_data0,
    input  logic [19:0] i_rx_data1,
    output logic        o_rx_valid,
    input  logic        i_rx_ready,
    output logic [71:0] o_rx_data,
    output logic        o_ns_fifo_full,
    output logic        o_fs_fifo_full,
    output logic [7:0]  o_par_err_cnt,
    output logic [7:0]  o_frm_err_cnt,
    output logic        o_overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
    localparam logic [CW-1:0] NS_THRESH  = CW'(DEPTH - FULL_MARGIN);

    typedef enum logic {IDLE, HALF} state_t;

    logic [19:0]   lane0_q, lane1_q;
    state_t        state_q;
    logic [35:0]   held_q;
    logic [7:0]    parErrCnt_q, frmErrCnt_q;
    logic [71:0]   mem_q [DEPTH];
    logic [AW-1:0] wrPtr_q, rdPtr_q;
    logic [CW-1:0] count_q, count_d;
    logic          overflow_q;

    logic [35:0]   beat;
    logic          beatValid, beatSof, parOk;
    logic          push, parInc, frmInc;
    logic [71:0]   pushData;
    logic          pop, full, accept;

    always_ff @(posedge i_aib_rx_clk) begin
        if (i_rst) begin
            lane0_q <= '0;
            lane1_q <= '0;
        end else begin
            lane0_q <= i_rx_data0;
            lane1_q <= i_rx_data1;
        end
    end

    assign beat      = {lane1_q[17:0], lane0_q[17:0]};
    assign beatValid = lane0_q[19];
    assign beatSof   = lane0_q[18];
    assign parOk     = ((^beat) == lane1_q[18]);
    assign pushData  = {beat, held_q};

    // Parity is judged first so a bad beat never also counts as a framing error.
    always_comb begin
        push   = 1'b0;
        parInc = 1'b0;
        frmInc = 1'b0;
        if (beatValid) begin
            if (!parOk) begin
                parInc = 1'b1;
            end else if (state_q == HALF) begin
                if (beatSof) frmInc = 1'b1;
                else         push   = 1'b1;
            end else if (!beatSof) begin
                frmInc = 1'b1;
            end
        end
    end

    always_ff @(posedge i_aib_rx_clk) begin
        if (i_rst) begin
            state_q     <= IDLE;
            held_q      <= '0;
            parErrCnt_q <= '0;
            frmErrCnt_q <= '0;
        end else begin
            if (parInc && parErrCnt_q != 8'hFF) parErrCnt_q <= parErrCnt_q + 8'd1;
            if (frmInc && frmErrCnt_q != 8'hFF) frmErrCnt_q <= frmErrCnt_q + 8'd1;
            if (beatValid) begin
                if (!parOk) begin
                    state_q <= IDLE;
                end else if (beatSof) begin
                    held_q  <= beat;
                    state_q <= HALF;
                end else begin
                    state_q <= IDLE;
                end
            end
        end
    end

    assign o_rx_valid = (count_q != '0);
    assign pop        = o_rx_valid & i_rx_ready;
    assign full       = (count_q == FULL_COUNT);
    assign accept     = push & (!full | pop);

    always_comb begin
        count_d = count_q;
        if (accept && !pop)      count_d = count_q + 1'b1;
        else if (!accept && pop) count_d = count_q - 1'b1;
    end

    always_ff @(posedge i_aib_rx_clk) begin
        if (i_rst) begin
            wrPtr_q    <= '0;
            rdPtr_q    <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (accept) wrPtr_q <= wrPtr_q + 1'b1;
            if (pop)    rdPtr_q <= rdPtr_q + 1'b1;
            count_q <= count_d;
            if (push && full && !pop) overflow_q <= 1'b1;
        end
    end

    // Storage is left unreset; the head is masked to zero whenever the queue is empty.
    always_ff @(posedge i_aib_rx_clk) begin
        if (accept) mem_q[wrPtr_q] <= pushData;
    end

    assign o_rx_data      = o_rx_valid ? mem_q[rdPtr_q] : '0;
    assign o_ns_fifo_full = (count_q >= NS_THRESH);
    assign o_fs_fifo_full = lane1_q[19];
    assign o_par_err_cnt  = parErrCnt_q;
    assign o_frm_err_cnt  = frmErrCnt_q;
    assign o_overflow     = overflow_q;

endmodule
